vedic_mult_nxn: RTL and testbench

//  Parametrised sequential Vedic (Urdhva-Tiryakbhyam) multiplier, WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/vedic_mult_nxn.sv | 225 ++++++++++++++++++++++
 tb/tb_vedic_mult_nxn.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_nxn.sv
// Sequential Urdhva-Tiryakbhyam multiplier, WIDTH x WIDTH -> 2*WIDTH, one crosswise column per cycle.
// Latency: m_tvalid rises 2*WIDTH-1 edges after the edge that captures the later operand.
// Backpressure: each operand channel drops tready after capture and re-opens only on the result handshake.
//
// Ports:
//   clk             rising-edge clock
//   arst            asynchronous, active-high reset (aborts any operation in flight)
//   s_a_tdata/_tvalid/_tready   operand A channel (valid/ready)
//   s_b_tdata/_tvalid/_tready   operand B channel (valid/ready)
//   m_result_tdata  2*WIDTH-bit product, registered, stable while m_tvalid=1
//   m_tvalid/m_tready           result channel (valid/ready)
//   busy            high while computing or holding a result
//
// Build option: define VEDIC_SIGNED_EN for two's complement operands/result; the column engine
// then multiplies magnitudes and the sign is applied when the result register is loaded.

module vedic_mult_nxn #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               arst,
   input  logic [WIDTH-1:0]   s_a_tdata,
   input  logic               s_a_tvalid,
   output logic               s_a_tready,
   input  logic [WIDTH-1:0]   s_b_tdata,
   input  logic               s_b_tvalid,
   output logic               s_b_tready,
   output logic [2*WIDTH-1:0] m_result_tdata,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               busy
);

   localparam int PW  = 2 * WIDTH;          // product width
   localparam int CW  = $clog2(WIDTH) + 2;  // column sum + carry
   localparam int CLW = $clog2(PW);         // column counter width
   localparam logic [CLW-1:0] LAST_COL = CLW'(PW - 2);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             a_cap_q, a_cap_d;
   logic             b_cap_q, b_cap_d;
   logic             sa_rdy_q, sa_rdy_d;
   logic             sb_rdy_q, sb_rdy_d;
   logic [CLW-1:0]   col_q, col_d;
   logic [CW-1:0]    carry_q, carry_d;
   logic [PW-2:0]    prod_q, prod_d;      // bits 0..PW-2; the top bit comes straight from the final carry
   logic [PW-1:0]    res_q, res_d;
   logic             m_vld_q, m_vld_d;
   logic             busy_q, busy_d;

   logic             a_hs;
   logic             b_hs;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [CW-1:0]    acc;
   logic [PW-1:0]    final_w;

   assign a_hs = s_a_tvalid & sa_rdy_q;
   assign b_hs = s_b_tvalid & sb_rdy_q;

`ifdef VEDIC_SIGNED_EN
   logic sign_a_q, sign_a_d;
   logic sign_b_q, sign_b_d;

   // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
   assign a_in = s_a_tdata[WIDTH-1] ? -s_a_tdata : s_a_tdata;
   assign b_in = s_b_tdata[WIDTH-1] ? -s_b_tdata : s_b_tdata;
`else
   assign a_in = s_a_tdata;
   assign b_in = s_b_tdata;
`endif

   // Column engine: row i contributes a[i] & b[col-i]. Shifting b left by i lines b[col-i]
   // up at bit position col, and the zero fill handles the out-of-range indices for free.
   // The rows are then summed as a short chain seeded with the running carry.
   logic [CW-1:0] psum [0:WIDTH];

   assign psum[0] = carry_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_row
      logic [PW-1:0] row_w;
      assign row_w       = PW'(b_q) << i;
      assign psum[i + 1] = psum[i] + CW'(a_q[i] & row_w[col_q]);
   end

   assign acc = psum[WIDTH];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      a_cap_d  = a_cap_q;
      b_cap_d  = b_cap_q;
      sa_rdy_d = sa_rdy_q;
      sb_rdy_d = sb_rdy_q;
      col_d    = col_q;
      carry_d  = carry_q;
      prod_d   = prod_q;
      res_d    = res_q;
      m_vld_d  = m_vld_q;
      final_w  = '0;
`ifdef VEDIC_SIGNED_EN
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
`endif

      // Operand capture is independent per channel; ready is only ever high in IDLE.
      if (a_hs) begin
         a_d      = a_in;
         a_cap_d  = 1'b1;
         sa_rdy_d = 1'b0;
`ifdef VEDIC_SIGNED_EN
         sign_a_d = s_a_tdata[WIDTH-1];
`endif
      end
      if (b_hs) begin
         b_d      = b_in;
         b_cap_d  = 1'b1;
         sb_rdy_d = 1'b0;
`ifdef VEDIC_SIGNED_EN
         sign_b_d = s_b_tdata[WIDTH-1];
`endif
      end

      case (state_q)
         S_IDLE: begin
            // Start on the same edge that captures the second operand.
            if ((a_cap_q | a_hs) && (b_cap_q | b_hs)) begin
               state_d = S_COMPUTE;
               col_d   = '0;
               carry_d = '0;
            end
         end

         S_COMPUTE: begin
            prod_d[col_q] = acc[0];
            carry_d       = acc >> 1;
            col_d         = col_q + 1'b1;
            if (col_q == LAST_COL) begin
               // The carry out of the last column is at most 1, so acc[1] is the MSB.
               final_w = {acc[1], prod_d};
`ifdef VEDIC_SIGNED_EN
               res_d   = (sign_a_q ^ sign_b_q) ? -final_w : final_w;
`else
               res_d   = final_w;
`endif
               m_vld_d = 1'b1;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            if (m_tready) begin
               m_vld_d  = 1'b0;
               sa_rdy_d = 1'b1;
               sb_rdy_d = 1'b1;
               a_cap_d  = 1'b0;
               b_cap_d  = 1'b0;
               state_d  = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         a_cap_q  <= 1'b0;
         b_cap_q  <= 1'b0;
         sa_rdy_q <= 1'b1;
         sb_rdy_q <= 1'b1;
         col_q    <= '0;
         carry_q  <= '0;
         prod_q   <= '0;
         res_q    <= '0;
         m_vld_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef VEDIC_SIGNED_EN
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a_cap_q  <= a_cap_d;
         b_cap_q  <= b_cap_d;
         sa_rdy_q <= sa_rdy_d;
         sb_rdy_q <= sb_rdy_d;
         col_q    <= col_d;
         carry_q  <= carry_d;
         prod_q   <= prod_d;
         res_q    <= res_d;
         m_vld_q  <= m_vld_d;
         busy_q   <= busy_d;
`ifdef VEDIC_SIGNED_EN
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
`endif
      end
   end

   assign s_a_tready     = sa_rdy_q;
   assign s_b_tready     = sb_rdy_q;
   assign m_result_tdata = res_q;
   assign m_tvalid       = m_vld_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_vedic_mult_nxn.sv
// Self-checking bench for vedic_mult_nxn: WIDTH=8 directed scenarios plus WIDTH=2 and WIDTH=5 sweeps.
// Latency: checked per operation against 2*WIDTH-1 edges from the later capture.
// Backpressure: result channel stalled in one scenario; operand readiness checked throughout.

module tb_vedic_mult_nxn;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // WIDTH = 8 instance
   logic [7:0]  a_dat, b_dat;
   logic        a_vld, b_vld, a_rdy, b_rdy;
   logic [15:0] m_dat;
   logic        m_vld, m_rdy, busy;

   // WIDTH = 5 instance
   logic [4:0]  a5_dat, b5_dat;
   logic        a5_vld, b5_vld, a5_rdy, b5_rdy;
   logic [9:0]  p5_dat;
   logic        p5_vld, busy5;
   logic        p5_rdy = 1'b1;

   // WIDTH = 2 instance
   logic [1:0]  a2_dat, b2_dat;
   logic        a2_vld, b2_vld, a2_rdy, b2_rdy;
   logic [3:0]  p2_dat;
   logic        p2_vld, busy2;
   logic        p2_rdy = 1'b1;

   vedic_mult_nxn #(.WIDTH(8)) u_dut8 (
      .clk(clk), .arst(arst),
      .s_a_tdata(a_dat), .s_a_tvalid(a_vld), .s_a_tready(a_rdy),
      .s_b_tdata(b_dat), .s_b_tvalid(b_vld), .s_b_tready(b_rdy),
      .m_result_tdata(m_dat), .m_tvalid(m_vld), .m_tready(m_rdy), .busy(busy)
   );

   vedic_mult_nxn #(.WIDTH(5)) u_dut5 (
      .clk(clk), .arst(arst),
      .s_a_tdata(a5_dat), .s_a_tvalid(a5_vld), .s_a_tready(a5_rdy),
      .s_b_tdata(b5_dat), .s_b_tvalid(b5_vld), .s_b_tready(b5_rdy),
      .m_result_tdata(p5_dat), .m_tvalid(p5_vld), .m_tready(p5_rdy), .busy(busy5)
   );

   vedic_mult_nxn #(.WIDTH(2)) u_dut2 (
      .clk(clk), .arst(arst),
      .s_a_tdata(a2_dat), .s_a_tvalid(a2_vld), .s_a_tready(a2_rdy),
      .s_b_tdata(b2_dat), .s_b_tvalid(b2_vld), .s_b_tready(b2_rdy),
      .m_result_tdata(p2_dat), .m_tvalid(p2_vld), .m_tready(p2_rdy), .busy(busy2)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Golden product of two w-bit operands, truncated to 2*w bits.
   function automatic logic [31:0] model(input int a, input int b, input int w);
      int sa;
      int sb;
      sa = a;
      sb = b;
`ifdef VEDIC_SIGNED_EN
      if (a >= (1 << (w - 1))) sa = a - (1 << w);
      if (b >= (1 << (w - 1))) sb = b - (1 << w);
`endif
      return 32'((sa * sb) & ((1 << (2 * w)) - 1));
   endfunction

   // Scoreboard for the WIDTH=8 instance: pushed at drive time, popped on each result handshake.
   logic [15:0] exp_q [$];

   always @(negedge clk) begin
      if (!arst && m_vld && m_rdy) begin
         chk_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk_eq("prod8", 32'(m_dat), 32'(exp_q.pop_front()));
      end
   end

   // Counts edges after the current point until m_vld is seen (bounded).
   task automatic wait_vld8(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!m_vld && n < 60);
   endtask

   // Presents both operands together while idle; returns #1 after the capture edge.
   task automatic drive_pair8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e,
                              input string tag);
      a_dat = a; b_dat = b; a_vld = 1'b1; b_vld = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      a_vld = 1'b0; b_vld = 1'b0;
      chk_eq({tag, "_rdy_lo"}, 32'({a_rdy, b_rdy}), 32'd0);
      chk_eq({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e,
                       input string tag);
      int n;
      drive_pair8(a, b, e, tag);
      wait_vld8(n);
      chk_eq({tag, "_lat"}, 32'(n), 32'd15);
      @(posedge clk); #1;
      chk_eq({tag, "_rdy_back"}, 32'({a_rdy, b_rdy, busy}), 32'b110);
   endtask

   logic [7:0]  t4a [4] = '{8'h12, 8'hFE, 8'h00, 8'h81};
   logic [7:0]  t4b [4] = '{8'h34, 8'h03, 8'h9C, 8'h7F};
   logic [7:0]  t6a [3] = '{8'h80, 8'h80, 8'h05};
   logic [7:0]  t6b [3] = '{8'hFF, 8'h80, 8'hFD};
`ifdef VEDIC_SIGNED_EN
   logic [15:0] t6e [3] = '{16'h0080, 16'h4000, 16'hFFF1};
`else
   logic [15:0] t6e [3] = '{16'h7F80, 16'h4000, 16'h04F1};
`endif

   logic [3:0]  q2 [$];
   logic [9:0]  q5 [$];

   initial begin : main
      int n;
      int k;
      int prev;
      a_dat = '0; b_dat = '0; a_vld = 1'b0; b_vld = 1'b0; m_rdy = 1'b1;
      a5_dat = '0; b5_dat = '0; a5_vld = 1'b0; b5_vld = 1'b0;
      a2_dat = '0; b2_dat = '0; a2_vld = 1'b0; b2_vld = 1'b0;
      prev = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_a_rdy", 32'(a_rdy), 32'd1);
      chk_eq("rst_b_rdy", 32'(b_rdy), 32'd1);
      chk_eq("rst_m_vld", 32'(m_vld), 32'd0);
      chk_eq("rst_m_dat", 32'(m_dat), 32'd0);
      chk_eq("rst_busy", 32'(busy), 32'd0);
      arst = 1'b0;
      @(posedge clk); #1;

      // 1: both operands together, all ones
      run8(8'hFF, 8'hFF, 16'(model(8'hFF, 8'hFF, 8)), "t1");

      // 2: A first, B three edges later
      a_dat = 8'h0C; a_vld = 1'b1;
      exp_q.push_back(16'(model(8'h0C, 8'h0A, 8)));
      @(posedge clk); #1;
      a_vld = 1'b0;
      chk_eq("t2_a_rdy", 32'(a_rdy), 32'd0);
      chk_eq("t2_b_rdy", 32'(b_rdy), 32'd1);
      chk_eq("t2_busy_idle", 32'(busy), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         chk_eq("t2_a_rdy_hold", 32'(a_rdy), 32'd0);
      end
      b_dat = 8'h0A; b_vld = 1'b1;
      @(posedge clk); #1;
      b_vld = 1'b0;
      chk_eq("t2_b_taken", 32'(b_rdy), 32'd0);
      wait_vld8(n);
      chk_eq("t2_lat", 32'(n), 32'd15);
      @(posedge clk); #1;

      // 3: result stalled for 10 cycles
      m_rdy = 1'b0;
      drive_pair8(8'h37, 8'h5B, 16'h138D, "t3");
      wait_vld8(n);
      chk_eq("t3_lat", 32'(n), 32'd15);
      repeat (10) begin
         @(posedge clk); #1;
         chk_eq("t3_vld_hold", 32'(m_vld), 32'd1);
         chk_eq("t3_dat_hold", 32'(m_dat), 32'h138D);
         chk_eq("t3_rdy_lo", 32'({a_rdy, b_rdy}), 32'd0);
      end
      m_rdy = 1'b1;
      @(posedge clk); #1;
      chk_eq("t3_release", 32'({m_vld, a_rdy, b_rdy}), 32'b011);

      // 4: streaming with operands always valid
      a_vld = 1'b1; b_vld = 1'b1;
      for (int p = 0; p < 4; p++) begin
         a_dat = t4a[p]; b_dat = t4b[p];
         exp_q.push_back(16'(model(int'(t4a[p]), int'(t4b[p]), 8)));
         k = 0;
         while (!a_rdy && k < 40) begin
            @(posedge clk); #1;
            k++;
         end
         @(posedge clk); #1;
         chk_eq("t4_taken", 32'({a_rdy, b_rdy}), 32'd0);
         if (p > 0) chk_eq("t4_period", 32'(cyc - prev), 32'd17);
         prev = cyc;
      end
      a_vld = 1'b0; b_vld = 1'b0;
      wait_vld8(n);
      chk_eq("t4_lat", 32'(n), 32'd15);
      @(posedge clk); #1;

      // 5: reset at column 5 aborts the operation
      drive_pair8(8'hAA, 8'h55, 16'(model(8'hAA, 8'h55, 8)), "t5");
      repeat (5) @(posedge clk);
      #1;
      arst = 1'b1;
      #1;
      chk_eq("t5_m_vld", 32'(m_vld), 32'd0);
      chk_eq("t5_m_dat", 32'(m_dat), 32'd0);
      chk_eq("t5_rdy", 32'({a_rdy, b_rdy}), 32'b11);
      chk_eq("t5_busy", 32'(busy), 32'd0);
      exp_q.delete();
      #1;
      arst = 1'b0;
      @(posedge clk); #1;
      run8(8'h03, 8'h07, 16'h0015, "t5b");

      // 6: sign corner cases (expectations follow the build)
      for (int p = 0; p < 3; p++) run8(t6a[p], t6b[p], t6e[p], "t6");

      // 7a: WIDTH=2 exhaustive
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            a2_dat = 2'(a); b2_dat = 2'(b); a2_vld = 1'b1; b2_vld = 1'b1;
            q2.push_back(4'(model(a, b, 2)));
            @(posedge clk); #1;
            a2_vld = 1'b0; b2_vld = 1'b0;
            chk_eq("w2_busy", 32'({busy2, a2_rdy, b2_rdy}), 32'b100);
            n = 0;
            do begin
               @(posedge clk); #1;
               n++;
            end while (!p2_vld && n < 20);
            chk_eq("w2_lat", 32'(n), 32'd3);
            chk_eq("w2_prod", 32'(p2_dat), 32'(q2.pop_front()));
            @(posedge clk); #1;
            chk_eq("w2_rdy", 32'({a2_rdy, b2_rdy}), 32'b11);
         end
      end

      // 7b: WIDTH=5 exhaustive
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            a5_dat = 5'(a); b5_dat = 5'(b); a5_vld = 1'b1; b5_vld = 1'b1;
            q5.push_back(10'(model(a, b, 5)));
            @(posedge clk); #1;
            a5_vld = 1'b0; b5_vld = 1'b0;
            chk_eq("w5_busy", 32'({busy5, a5_rdy, b5_rdy}), 32'b100);
            n = 0;
            do begin
               @(posedge clk); #1;
               n++;
            end while (!p5_vld && n < 40);
            chk_eq("w5_lat", 32'(n), 32'd9);
            chk_eq("w5_prod", 32'(p5_dat), 32'(q5.pop_front()));
            @(posedge clk); #1;
         end
      end

      chk_eq("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
